onchip_mem_arbiter: RTL and testbench
=====================================

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 SHALL have parameter BURST_MAX, default 4, range 1..15, max consecutive grants to one master while the other waits.
REQ-004 SHALL have ports clk  in  1  system clock; reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have, per master N in {0,1}: mN_address  in  ADDR_W  word address; mN_byteenable  in  DATA_W/8  byte lanes; mN_read  in  1  read request; mN_write  in  1  write request; mN_writedata  in  DATA_W  write data.
REQ-006 SHALL have, per master N: mN_waitrequest  out  1  request not accepted this cycle; mN_readdata  out  DATA_W  read data; mN_readdatavalid  out  1  mN_readdata valid.
REQ-007 SHALL have memory-side ports: mem_address  out  ADDR_W; mem_byteenable  out  DATA_W/8; mem_chipselect  out  1; mem_write  out  1; mem_writedata  out  DATA_W; mem_readdata  in  DATA_W.

Function
REQ-008 A master requests when mN_read or mN_write is high; read and write together SHALL be treated as a write.
REQ-009 At most one master SHALL be granted per cycle; the granted master's mN_waitrequest SHALL be low in that same cycle, all others high while requesting.
REQ-010 mN_waitrequest SHALL be high for a non-requesting master.
REQ-011 Grant path SHALL be combinational: mem_address/byteenable/writedata from the granted master, mem_chipselect=1, mem_write=granted write.
REQ-012 With no grant, mem_chipselect and mem_write SHALL be 0; other mem outputs are don't-care.
REQ-013 An accepted write SHALL complete in its grant cycle, no response.
REQ-014 An accepted read SHALL assert that master's mN_readdatavalid exactly 1 cycle later for 1 cycle; mN_readdata SHALL equal mem_readdata (broadcast to both masters).
REQ-015 Back-to-back reads SHALL be accepted every cycle (fully pipelined, 1 read in flight per cycle).
REQ-016 FSM states: IDLE, OWN0, OWN1; 4-bit hold counter cnt; 1-bit last-served pointer last.
REQ-017 IDLE: one requester -> grant it; both -> grant the master != last; go OWNx, cnt=1, last=x; none -> stay IDLE.
REQ-018 OWNx, owner requests, other idle -> grant owner, cnt saturating increment at BURST_MAX.
REQ-019 OWNx, both request, cnt<BURST_MAX -> grant owner, cnt+1.
REQ-020 OWNx, both request, cnt==BURST_MAX -> grant other, go OWNother, cnt=1, last=other.
REQ-021 OWNx, only other requests -> grant other, go OWNother, cnt=1.
REQ-022 OWNx, no requests -> IDLE, cnt=0, last unchanged.
REQ-023 Master dropping request while held off SHALL leave no pending state.

Reset
REQ-024 reset_n low SHALL asynchronously force state=IDLE, cnt=0, last=1 (master 0 wins first tie), both mNreaddatavalid=0.
REQ-025 Reads accepted in the cycle before reset assertion SHALL NOT produce readdatavalid after reset.
REQ-026 Combinational outputs SHALL follow REQ-009..012 from reset values during reset (waitrequest high to requesters, mem_chipselect 0).

Structure
REQ-027 FSM state encoding and BURST_MAX default SHALL live in shared package onchip_mem_pkg.
REQ-028 Round-robin/hold decision SHALL be sub-module rr_hold_arb (inputs req[1:0], outputs grant[1:0]); datapath mux and readdatavalid pipe in top.

Verification
REQ-029 m0 read addr 0x0010 alone -> m0_waitrequest 0 same cycle, mem_address=0x0010, m0_readdatavalid 1 next cycle with mem_readdata.
REQ-030 Both read continuously from reset, BURST_MAX=4 -> grant pattern 0,0,0,0,1,1,1,1,0... 
REQ-031 Both request in IDLE after m1 last served -> m0 granted, m1_waitrequest 1.
REQ-032 m1 write 0xDEADBEEF, byteenable 0x3, addr 0x3FFF -> mem_write 1, mem_byteenable 0x3, no readdatavalid.
REQ-033 read+write asserted together by m0 -> treated as write, mem_write 1, no readdatavalid.
REQ-034 reset_n low 1 cycle after accepted read -> readdatavalid stays 0, next tie grants m0.

Source files
------------

// File: rtl/onchip_mem_pkg.sv
// Shared definitions for the two-master on-chip memory arbiter: FSM encoding,
// hold-counter sizing and the default burst limit.
package onchip_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam int CNT_W         = 4;
  localparam int BURST_MAX_DEF = 4;

  function automatic logic [1:0] own_state(input logic master);
    return master ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/rr_hold_arb.sv
// Two-way round-robin arbiter that keeps granting the current owner for up to
// BURST_MAX consecutive cycles while the other master is waiting.
module rr_hold_arb
  import onchip_mem_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last_nxt;
  logic [1:0]       w_grant;
  logic             w_owner;
  logic             w_sel;

  // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_grant     = 2'b00;
    w_owner     = (r_state == ST_OWN1);
    w_sel       = 1'b0;
    case (r_state)
      ST_OWN0, ST_OWN1: begin
        if (req[w_owner] && (!req[!w_owner] || (r_cnt < CNT_MAX))) begin
          w_grant[w_owner] = 1'b1;
          w_cnt_nxt        = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
        end else if (req[!w_owner]) begin
          w_grant[!w_owner] = 1'b1;
          w_state_nxt       = own_state(!w_owner);
          w_cnt_nxt         = CNT_ONE;
          w_last_nxt        = !w_owner;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        if (|req) begin
          // On a tie the master that was not served last goes first.
          w_sel          = (req == 2'b11) ? !r_last : req[1];
          w_grant[w_sel] = 1'b1;
          w_state_nxt    = own_state(w_sel);
          w_cnt_nxt      = CNT_ONE;
          w_last_nxt     = w_sel;
        end
      end
    endcase
  end

  // NOTE: grants are masked while reset is held so nothing reaches memory mid-reset.
  assign grant = w_grant & {2{reset_n}};

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-cycle on-chip memory between two masters: combinational
// grant path to the memory and a one-cycle read-valid pipe back to the masters.
module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic [1:0] w_req;
  logic [1:0] w_grant;
  logic [1:0] w_rd_accept;
  logic       w_sel;
  logic [1:0] r_rdv;

  assign w_req = {m1_read | m1_write, m0_read | m0_write};

  rr_hold_arb #(
    .BURST_MAX (BURST_MAX)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (w_req),
    .grant   (w_grant)
  );

  assign w_sel          = w_grant[1];
  assign m0_waitrequest = !w_grant[0];
  assign m1_waitrequest = !w_grant[1];

  assign mem_chipselect = |w_grant;
  assign mem_write      = (w_grant[0] & m0_write) | (w_grant[1] & m1_write);
  assign mem_address    = w_sel ? m1_address    : m0_address;
  assign mem_byteenable = w_sel ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = w_sel ? m1_writedata  : m0_writedata;

  // Read together with write is a write, so it never expects a response.
  assign w_rd_accept = {w_grant[1] & m1_read & !m1_write,
                        w_grant[0] & m0_read & !m0_write};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdv <= 2'b00;
    end else begin
      r_rdv <= w_rd_accept;
    end
  end

  assign m0_readdatavalid = r_rdv[0];
  assign m1_readdatavalid = r_rdv[1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench for onchip_mem_arbiter: directed vectors push expected grants
// and read responses; a negedge monitor pops and compares them.
module tb_onchip_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [13:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_readdata;

  typedef struct {
    int          cyc;
    int          master;
    logic [13:0] addr;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } grant_exp_t;

  typedef struct {
    int          cyc;
    int          master;
    logic [31:0] data;
  } rd_exp_t;

  grant_exp_t gq[$];
  rd_exp_t    rq[$];
  int         cyc      = 0;
  int         n_checks = 0;
  int         n_fail   = 0;

  onchip_mem_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_readdata     (mem_readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory content is a fixed function of the address, returned one cycle after a read.
  function automatic logic [31:0] mem_model(input logic [13:0] a);
    return {18'h0, a} ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) begin
    if (mem_chipselect && !mem_write) mem_readdata <= mem_model(mem_address);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic r0, input logic w0, input logic [13:0] a0,
                      input logic [3:0] be0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [13:0] a1,
                      input logic [3:0] be1, input logic [31:0] d1,
                      input int exp_m, input bit push_rd, input bit rst);
    grant_exp_t g;
    rd_exp_t    r;
    @(posedge clk);
    #1;
    reset_n       = rst;
    m0_read       = r0;  m0_write      = w0;  m0_address = a0;
    m0_byteenable = be0; m0_writedata  = d0;
    m1_read       = r1;  m1_write      = w1;  m1_address = a1;
    m1_byteenable = be1; m1_writedata  = d1;
    g.cyc    = cyc;
    g.master = exp_m;
    g.addr   = (exp_m == 1) ? a1  : a0;
    g.wr     = (exp_m == 1) ? w1  : w0;
    g.be     = (exp_m == 1) ? be1 : be0;
    g.wdata  = (exp_m == 1) ? d1  : d0;
    gq.push_back(g);
    if (exp_m >= 0 && push_rd && !g.wr) begin
      r.cyc    = cyc + 1;
      r.master = exp_m;
      r.data   = mem_model(g.addr);
      rq.push_back(r);
    end
  endtask

  task automatic idle();
    step(0, 0, 14'h0, 4'h0, 32'h0, 0, 0, 14'h0, 4'h0, 32'h0, -1, 0, 1);
  endtask

  task automatic rd(input logic r0, input logic [13:0] a0, input logic r1,
                    input logic [13:0] a1, input int exp_m, input bit push_rd, input bit rst);
    step(r0, 0, a0, 4'hF, 32'h0, r1, 0, a1, 4'hF, 32'h0, exp_m, push_rd, rst);
  endtask

  // Monitor: compares the grant expected for this cycle and any due read response.
  always @(negedge clk) begin
    grant_exp_t g;
    rd_exp_t    r;
    logic       exp_v0, exp_v1;
    while (gq.size() > 0 && gq[0].cyc < cyc) begin
      check("grant_expectation_stale", gq[0].cyc, cyc);
      void'(gq.pop_front());
    end
    if (gq.size() > 0 && gq[0].cyc == cyc) begin
      g = gq.pop_front();
      check("m0_waitrequest", m0_waitrequest, g.master != 0);
      check("m1_waitrequest", m1_waitrequest, g.master != 1);
      check("mem_chipselect", mem_chipselect, g.master >= 0);
      if (g.master >= 0) begin
        check("mem_address", mem_address, g.addr);
        check("mem_byteenable", mem_byteenable, g.be);
        check("mem_write", mem_write, g.wr);
        if (g.wr) check("mem_writedata", mem_writedata, g.wdata);
      end else begin
        check("mem_write_idle", mem_write, 1'b0);
      end
    end
    exp_v0 = rq.size() > 0 && rq[0].cyc == cyc && rq[0].master == 0;
    exp_v1 = rq.size() > 0 && rq[0].cyc == cyc && rq[0].master == 1;
    check("m0_readdatavalid", m0_readdatavalid, exp_v0);
    check("m1_readdatavalid", m1_readdatavalid, exp_v1);
    if (exp_v0 || exp_v1) begin
      r = rq.pop_front();
      check("readdata", (r.master == 0) ? m0_readdata : m1_readdata, r.data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;

    // Requests during reset see waitrequest high and no chipselect.
    rd(1, 14'h0005, 1, 14'h0006, -1, 0, 0);
    rd(1, 14'h0005, 0, 14'h0000, -1, 0, 0);

    // Both reading from reset: four grants to m0, four to m1, then m0 again.
    for (int i = 0; i < 10; i++)
      rd(1, 14'h0100 + 14'(i), 1, 14'h0200 + 14'(i), (i < 4) ? 0 : ((i < 8) ? 1 : 0), 1, 1);
    idle();

    // Lone read from m0, then tie after m1 was last served goes to m0.
    rd(1, 14'h0010, 0, 14'h0000, 0, 1, 1);
    idle();
    rd(0, 14'h0000, 1, 14'h0020, 1, 1, 1);
    idle();
    rd(1, 14'h0030, 1, 14'h0040, 0, 1, 1);
    idle();

    // m1 write at top address, then m0 read+write counted as a write.
    step(0, 0, 14'h0, 4'h0, 32'h0, 0, 1, 14'h3FFF, 4'h3, 32'hDEAD_BEEF, 1, 1, 1);
    idle();
    step(1, 1, 14'h0055, 4'hF, 32'h1234_5678, 0, 0, 14'h0, 4'h0, 32'h0, 0, 1, 1);
    idle();

    // Counter saturates while m0 streams alone, so a late m1 request wins at once.
    for (int i = 0; i < 6; i++) rd(1, 14'h0300 + 14'(i), 0, 14'h0, 0, 1, 1);
    rd(1, 14'h0310, 1, 14'h0400, 1, 1, 1);
    rd(1, 14'h0311, 0, 14'h0000, 0, 1, 1);
    rd(1, 14'h0312, 1, 14'h0401, 0, 1, 1);
    rd(1, 14'h0313, 0, 14'h0000, 0, 1, 1);
    idle();
    rd(1, 14'h0320, 1, 14'h0410, 1, 1, 1);
    idle();

    // Reset right after an accepted read kills its response; next tie goes to m0.
    rd(1, 14'h0077, 0, 14'h0000, 0, 0, 1);
    rd(1, 14'h0078, 1, 14'h0079, -1, 0, 0);
    rd(1, 14'h0078, 1, 14'h0079, -1, 0, 0);
    rd(1, 14'h0080, 1, 14'h0081, 0, 1, 1);
    idle();
    idle();

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(gq.size() + rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
